div_iter_unit: RTL and testbench

- Iterative 32-cycle restoring divider serving DIV/DIVU in the Execute stage.
- It is the stall source that the hazard unit consumes. It drives `stall_req` while a division is in flight, so the pipeline holds with the divide in EX.
- It releases the stall for exactly one cycle, with the quotient and remainder valid, so the HILO write proceeds down the pipeline on the normal forwarding path.

---
 rtl/div_iter_unit.sv | 146 ++++++++++++++
 tb/tb_div_iter_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter_unit.sv
// div_iter_unit: iterative restoring divider for DIV/DIVU in the Execute stage.
//
// It takes one cycle to capture the operands and then WIDTH cycles to iterate.
// While the divide is in flight it holds the pipeline through stall_req. It then
// releases the stall for exactly one cycle, with done high and the results valid.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; operands captured on start & ~flush
// DIV   | one shift/trial-subtract per cycle, WIDTH iterations
// DONE  | results visible, stall released, done pulse (one cycle)
//
// Ports:
//   clk        system clock, rising edge
//   resetn     asynchronous active-low reset
//   start      level, high while a divide sits in EX (held during stall)
//   signed_div 1 = DIV (two's complement), 0 = DIVU; sampled with start
//   a, b       dividend / divisor
//   flush      abort the current operation
//   stall_req  freeze F/D/E while high
//   done       one-cycle pulse, quotient/remainder valid
//   quotient   result to LO
//   remainder  result to HI

module div_iter_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] divisorMag;
    logic [WIDTH-1:0] quoReg;
    logic [WIDTH-1:0] remReg;
    logic             quoNeg;
    logic             remNeg;
    logic             doneReg;

    logic             aNeg;
    logic             bNeg;
    logic [WIDTH-1:0] aMag;
    logic [WIDTH-1:0] bMag;
    logic [WIDTH:0]   partial;
    logic [WIDTH-1:0] diff;
    logic             noBorrow;
    logic [WIDTH-1:0] nextRem;
    logic [WIDTH-1:0] nextQuo;

    always_comb begin
        aNeg = signed_div & a[WIDTH-1];
        bNeg = signed_div & b[WIDTH-1];
        aMag = aNeg ? -a : a;
        bMag = bNeg ? -b : b;

        // The partial remainder is always below the divisor, so the shifted value fits
        // in WIDTH+1 bits. When there is no borrow, the low WIDTH bits of the modular
        // difference are the true difference.
        partial  = {remReg, quoReg[WIDTH-1]};
        noBorrow = (partial >= {1'b0, divisorMag});
        diff     = partial[WIDTH-1:0] - divisorMag;
        nextRem  = noBorrow ? diff : partial[WIDTH-1:0];
        nextQuo  = {quoReg[WIDTH-2:0], noBorrow};
    end

    // The stall must rise in the same cycle as start, so it cannot wait for a register.
    assign stall_req = resetn & ~flush & (((state == IDLE) & start) | (state == DIV));
    assign done      = doneReg & ~flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            count      <= '0;
            divisorMag <= '0;
            quoReg     <= '0;
            remReg     <= '0;
            quoNeg     <= 1'b0;
            remNeg     <= 1'b0;
            doneReg    <= 1'b0;
            quotient   <= '0;
            remainder  <= '0;
        end else begin
            doneReg <= 1'b0;
            if (flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            quoNeg     <= aNeg ^ bNeg;
                            remNeg     <= aNeg;
                            divisorMag <= bMag;
                            quoReg     <= aMag;
                            remReg     <= '0;
                            count      <= '0;
                            if (b == '0) begin
                                // Divide by zero: fixed result, the remainder is the raw dividend.
                                quotient  <= '1;
                                remainder <= a;
                                doneReg   <= 1'b1;
                                state     <= DONE;
                            end else begin
                                state <= DIV;
                            end
                        end
                    end
                    DIV: begin
                        remReg <= nextRem;
                        quoReg <= nextQuo;
                        count  <= count + 1'b1;
                        if (count == CNT_W'(WIDTH - 1)) begin
                            quotient  <= quoNeg ? -nextQuo : nextQuo;
                            remainder <= remNeg ? -nextRem : nextRem;
                            doneReg   <= 1'b1;
                            state     <= DONE;
                        end
                    end
                    DONE: begin
                        // start is still high here for the same instruction leaving EX.
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_iter_unit.sv
module tb_div_iter_unit;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        signedDiv;
    logic [31:0] aIn;
    logic [31:0] bIn;
    logic        flush;
    logic        stallReq;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int nCompared;
    int nMismatched;

    div_iter_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signedDiv),
        .a          (aIn),
        .b          (bIn),
        .flush      (flush),
        .stall_req  (stallReq),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Full divide: start in cycle 0, DIV in cycles 1..32, DONE in cycle 33, IDLE in cycle 34.
    // The operands are corrupted after capture to show that they were latched.
    task automatic run_divide(input logic sd, input logic [31:0] av, input logic [31:0] bv,
                              input logic [31:0] expQ, input logic [31:0] expR, input string name);
        @(negedge clk);
        start = 1'b1; signedDiv = sd; aIn = av; bIn = bv;
        #1;
        nCompared++;
        if (stallReq !== 1'b1) begin
            nMismatched++;
            $display("FAIL %s cyc0 stall_req: got %b want 1", name, stallReq);
        end
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            if (c == 1) begin aIn = ~av; bIn = bv + 32'd1; signedDiv = ~sd; end
            #1;
            nCompared++;
            if (stallReq !== 1'b1 || done !== 1'b0) begin
                nMismatched++;
                $display("FAIL %s cyc%0d busy: stall_req=%b done=%b want 1/0", name, c, stallReq, done);
            end
        end
        @(negedge clk);
        #1;
        nCompared++;
        if (done !== 1'b1 || stallReq !== 1'b0) begin
            nMismatched++;
            $display("FAIL %s cyc33 done/stall: got %b/%b want 1/0", name, done, stallReq);
        end
        nCompared++;
        if (quotient !== expQ) begin
            nMismatched++;
            $display("FAIL %s quotient: got %h want %h", name, quotient, expQ);
        end
        nCompared++;
        if (remainder !== expR) begin
            nMismatched++;
            $display("FAIL %s remainder: got %h want %h", name, remainder, expR);
        end
        start = 1'b0; aIn = '0; bIn = '0; signedDiv = 1'b0;
        @(negedge clk);
        #1;
        nCompared++;
        if (done !== 1'b0 || stallReq !== 1'b0) begin
            nMismatched++;
            $display("FAIL %s cyc34 idle: done=%b stall_req=%b want 0/0", name, done, stallReq);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b1; signedDiv = 1'b0; aIn = 32'd5; bIn = 32'd1; flush = 1'b0;
        #1;
        nCompared++;
        if (stallReq !== 1'b0 || done !== 1'b0) begin
            nMismatched++;
            $display("FAIL reset stall/done: got %b/%b want 0/0", stallReq, done);
        end
        nCompared++;
        if (quotient !== 32'd0 || remainder !== 32'd0) begin
            nMismatched++;
            $display("FAIL reset results: got %h/%h want 0/0", quotient, remainder);
        end
        repeat (2) @(negedge clk);
        start = 1'b0;
        resetn = 1'b1;
        #1;
        nCompared++;
        if (stallReq !== 1'b0 || done !== 1'b0) begin
            nMismatched++;
            $display("FAIL post-reset idle: stall/done %b/%b want 0/0", stallReq, done);
        end
    endtask

    task automatic test_unsigned();
        run_divide(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, "divu_100_7");
    endtask

    task automatic test_signed();
        run_divide(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div_m7_2");
        run_divide(1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, "divu_fff9_2");
    endtask

    task automatic test_overflow();
        run_divide(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, "div_min_m1");
        run_divide(1'b1, 32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0, "div_min_min");
    endtask

    task automatic test_div_zero();
        @(negedge clk);
        start = 1'b1; signedDiv = 1'b1; aIn = 32'h1234_5678; bIn = 32'd0;
        #1;
        nCompared++;
        if (stallReq !== 1'b1) begin
            nMismatched++;
            $display("FAIL divzero cyc0 stall_req: got %b want 1", stallReq);
        end
        @(negedge clk);
        #1;
        nCompared++;
        if (done !== 1'b1 || stallReq !== 1'b0) begin
            nMismatched++;
            $display("FAIL divzero cyc1 done/stall: got %b/%b want 1/0", done, stallReq);
        end
        nCompared++;
        if (quotient !== 32'hFFFF_FFFF || remainder !== 32'h1234_5678) begin
            nMismatched++;
            $display("FAIL divzero results: got %h/%h want ffffffff/12345678", quotient, remainder);
        end
        start = 1'b0;
        @(negedge clk);
        #1;
        nCompared++;
        if (done !== 1'b0 || stallReq !== 1'b0) begin
            nMismatched++;
            $display("FAIL divzero cyc2 idle: done/stall %b/%b want 0/0", done, stallReq);
        end
    endtask

    task automatic test_flush();
        // flush together with start in IDLE starts nothing
        @(negedge clk);
        start = 1'b1; flush = 1'b1; signedDiv = 1'b0; aIn = 32'd50; bIn = 32'd5;
        #1;
        nCompared++;
        if (stallReq !== 1'b0) begin
            nMismatched++;
            $display("FAIL idleflush stall_req: got %b want 0", stallReq);
        end
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        nCompared++;
        if (stallReq !== 1'b0 || done !== 1'b0) begin
            nMismatched++;
            $display("FAIL idleflush next: stall/done %b/%b want 0/0", stallReq, done);
        end

        // flush in cycle 10 of a divide
        @(negedge clk);
        start = 1'b1; aIn = 32'd1000; bIn = 32'd3;
        for (int c = 1; c <= 9; c++) @(negedge clk);
        flush = 1'b1;
        #1;
        nCompared++;
        if (stallReq !== 1'b0 || done !== 1'b0) begin
            nMismatched++;
            $display("FAIL flush cyc10: stall/done %b/%b want 0/0", stallReq, done);
        end
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        #1;
        nCompared++;
        if (stallReq !== 1'b0 || done !== 1'b0) begin
            nMismatched++;
            $display("FAIL flush cyc11 idle: stall/done %b/%b want 0/0", stallReq, done);
        end
        nCompared++;
        if (quotient !== 32'hFFFF_FFFF || remainder !== 32'h1234_5678) begin
            nMismatched++;
            $display("FAIL flush held results: got %h/%h want ffffffff/12345678", quotient, remainder);
        end
        // restart in cycle 12, done expected in cycle 45
        @(negedge clk);
        start = 1'b1;
        for (int c = 12; c <= 44; c++) begin
            if (c > 12) @(negedge clk);
            #1;
            nCompared++;
            if (stallReq !== 1'b1 || done !== 1'b0) begin
                nMismatched++;
                $display("FAIL flush restart cyc%0d: stall/done %b/%b want 1/0", c, stallReq, done);
            end
        end
        @(negedge clk);
        #1;
        nCompared++;
        if (done !== 1'b1 || quotient !== 32'd333 || remainder !== 32'd1) begin
            nMismatched++;
            $display("FAIL flush restart cyc45: done=%b q=%0d r=%0d want 1/333/1", done, quotient, remainder);
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        start = 1'b1; signedDiv = 1'b0; aIn = 32'hDEAD_BEEF; bIn = 32'h0000_1234;
        for (int c = 1; c <= 20; c++) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        nCompared++;
        if (stallReq !== 1'b0 || done !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0) begin
            nMismatched++;
            $display("FAIL async reset: stall=%b done=%b q=%h r=%h want all 0", stallReq, done, quotient, remainder);
        end
        start = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        nCompared++;
        if (stallReq !== 1'b0 || done !== 1'b0) begin
            nMismatched++;
            $display("FAIL after async reset: stall/done %b/%b want 0/0", stallReq, done);
        end
        run_divide(1'b0, 32'hDEAD_BEEF, 32'h0000_1234, 32'd801701, 32'd1899, "divu_after_reset");
    endtask

    initial begin
        nCompared = 0;
        nMismatched = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_overflow();
        test_div_zero();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
